// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master arbiter sharing one word-wide memory port between an
//            instruction fetch path and a data load/store path. Each side
//            latches a single outstanding request. Data normally has
//            priority. A starve counter forces an instruction grant after
//            STARVE_LIMIT data grants have been made over a waiting fetch.
// Ports    : clk, reset_n              clock, synchronous active-low reset
//            imem_*                    instruction request / response
//            dmem_*                    data request / response
//            mem_*                     shared memory port (ack-terminated)
// Config   : MEM_ARBITER_BYTE_LANE_EN  when defined, writes drive per-lane
//            byte enables with lane-aligned write data, and reads return
//            data shifted down to the addressed byte. When undefined, all
//            four byte enables are driven and data passes through unshifted.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    // instruction side
    input  logic [31:0] imem_address,
    input  logic        imem_enable,
    output logic [31:0] imem_data,
    output logic        imem_wait,
    // data side
    input  logic [31:0] dmem_address,
    input  logic        dmem_enable,
    input  logic [31:0] dmem_write_data,
    input  logic        dmem_write_enable,
    input  logic [2:0]  dmem_write_mode,
    input  logic        dmem_read_enable,
    input  logic [2:0]  dmem_read_mode,
    output logic [31:0] dmem_read_data,
    output logic        dmem_wait,
    // memory side
    output logic [31:0] mem_address,
    output logic        mem_req,
    output logic        mem_write,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ack
);

    localparam int              c_CW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CW-1:0] c_STARVE_MAX = c_CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    state_t            r_state;

    // captured requests
    logic              r_i_pending;
    logic [31:0]       r_i_addr;
    logic              r_d_pending;
    logic [31:0]       r_d_addr;
    logic [31:0]       r_d_wdata;
    logic [2:0]        r_d_wmode;
    logic              r_d_write;

    logic [c_CW-1:0]   r_starve;

    // registered outputs
    logic [31:0]       r_imem_data;
    logic [31:0]       r_dmem_rdata;
    logic              r_mem_req;
    logic [31:0]       r_mem_addr;
    logic              r_mem_write;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;

    // combinational helpers
    logic              w_i_cap;
    logic              w_d_cap;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_d;
    logic              w_grant_i;
    logic [31:0]       w_i_src_addr;
    logic [31:0]       w_d_src_addr;
    logic [31:0]       w_d_src_wdata;
    logic [2:0]        w_d_src_wmode;
    logic              w_d_src_write;
    logic [3:0]        w_d_be;
    logic [31:0]       w_d_wdata_lane;
    logic [31:0]       w_rdata_lane;
    logic              w_unused;

    // A request is accepted only when its side has nothing outstanding.
    // dmem_enable alone (no read or write) is not a request.
    assign w_i_cap = imem_enable & ~r_i_pending;
    assign w_d_cap = dmem_enable & (dmem_read_enable | dmem_write_enable) & ~r_d_pending;

    // Arbitration considers requests being captured on this very edge so a
    // fresh request reaches mem_req one cycle after capture.
    assign w_i_req = r_i_pending | w_i_cap;
    assign w_d_req = r_d_pending | w_d_cap;

    assign w_grant_d = w_d_req & (~w_i_req | (r_starve != c_STARVE_MAX));
    assign w_grant_i = w_i_req & ~w_grant_d;

    // Source of the granted request: the held copy if already pending,
    // otherwise the live inputs being captured this edge.
    assign w_i_src_addr  = r_i_pending ? r_i_addr  : imem_address;
    assign w_d_src_addr  = r_d_pending ? r_d_addr  : dmem_address;
    assign w_d_src_wdata = r_d_pending ? r_d_wdata : dmem_write_data;
    assign w_d_src_wmode = r_d_pending ? r_d_wmode : dmem_write_mode;
    assign w_d_src_write = r_d_pending ? r_d_write : dmem_write_enable;

`ifdef MEM_ARBITER_BYTE_LANE_EN
    always_comb begin
        w_d_be         = 4'b1111;
        w_d_wdata_lane = w_d_src_wdata << {w_d_src_addr[1:0], 3'b000};
        if (w_d_src_write) begin
            case (w_d_src_wmode)
                3'b000:  w_d_be = 4'b0001 << w_d_src_addr[1:0];
                3'b001:  w_d_be = 4'b0011 << w_d_src_addr[1:0];
                default: w_d_be = 4'b1111;
            endcase
        end
    end

    // r_d_addr is stable for the whole data grant, so it selects the lane.
    assign w_rdata_lane = mem_read_data >> {r_d_addr[1:0], 3'b000};
`else
    assign w_d_be         = 4'b1111;
    assign w_d_wdata_lane = w_d_src_wdata;
    assign w_rdata_lane   = mem_read_data;
`endif

    // Byte offsets, write mode (without lane support) and read mode carry no
    // function on a word-wide port with word-sized read returns.
    assign w_unused = ^{w_i_src_addr[1:0], w_d_src_addr[1:0], w_d_src_wmode, dmem_read_mode};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_i_pending  <= 1'b0;
            r_i_addr     <= 32'd0;
            r_d_pending  <= 1'b0;
            r_d_addr     <= 32'd0;
            r_d_wdata    <= 32'd0;
            r_d_wmode    <= 3'd0;
            r_d_write    <= 1'b0;
            r_starve     <= '0;
            r_imem_data  <= 32'd0;
            r_dmem_rdata <= 32'd0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_write  <= 1'b0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'd0;
        end else begin
            if (w_i_cap) begin
                r_i_pending <= 1'b1;
                r_i_addr    <= imem_address;
            end

            // A request with both enables set is treated as a write.
            if (w_d_cap) begin
                r_d_pending <= 1'b1;
                r_d_addr    <= dmem_address;
                r_d_wdata   <= dmem_write_data;
                r_d_wmode   <= dmem_write_mode;
                r_d_write   <= dmem_write_enable;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= S_GRANT_D;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {w_d_src_addr[31:2], 2'b00};
                        r_mem_write <= w_d_src_write;
                        r_mem_be    <= w_d_be;
                        r_mem_wdata <= w_d_wdata_lane;
                        // Only grants that pass over an already-waiting fetch count.
                        if (r_i_pending && (r_starve != c_STARVE_MAX)) begin
                            r_starve <= r_starve + c_CW'(1);
                        end
                    end else if (w_grant_i) begin
                        r_state     <= S_GRANT_I;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {w_i_src_addr[31:2], 2'b00};
                        r_mem_write <= 1'b0;
                        r_mem_be    <= 4'b1111;
                        r_starve    <= '0;
                    end
                end

                S_GRANT_I: begin
                    if (mem_ack) begin
                        r_state     <= S_IDLE;
                        r_mem_req   <= 1'b0;
                        r_imem_data <= mem_read_data;
                        r_i_pending <= 1'b0;
                    end
                end

                S_GRANT_D: begin
                    if (mem_ack) begin
                        r_state     <= S_IDLE;
                        r_mem_req   <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (!r_d_write) begin
                            r_dmem_rdata <= w_rdata_lane;
                        end
                        r_d_pending <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_data      = r_imem_data;
    assign imem_wait      = r_i_pending;
    assign dmem_read_data = r_dmem_rdata;
    assign dmem_wait      = r_d_pending;
    assign mem_address    = r_mem_addr;
    assign mem_req        = r_mem_req;
    assign mem_write      = r_mem_write;
    assign mem_byte_en    = r_mem_be;
    assign mem_write_data = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A transaction-level model
//            tracks who owns the memory port, what each side has outstanding
//            and what each side should read back; the DUT is compared against
//            it every cycle, with extra directed checks on key scenarios.
// Config   : honours MEM_ARBITER_BYTE_LANE_EN for lane/shift expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_address;
    logic        imem_enable;
    logic [31:0] imem_data;
    logic        imem_wait;
    logic [31:0] dmem_address;
    logic        dmem_enable;
    logic [31:0] dmem_write_data;
    logic        dmem_write_enable;
    logic [2:0]  dmem_write_mode;
    logic        dmem_read_enable;
    logic [2:0]  dmem_read_mode;
    logic [31:0] dmem_read_data;
    logic        dmem_wait;
    logic [31:0] mem_address;
    logic        mem_req;
    logic        mem_write;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ack;

    mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_address(imem_address), .imem_enable(imem_enable),
        .imem_data(imem_data), .imem_wait(imem_wait),
        .dmem_address(dmem_address), .dmem_enable(dmem_enable),
        .dmem_write_data(dmem_write_data), .dmem_write_enable(dmem_write_enable),
        .dmem_write_mode(dmem_write_mode), .dmem_read_enable(dmem_read_enable),
        .dmem_read_mode(dmem_read_mode), .dmem_read_data(dmem_read_data),
        .dmem_wait(dmem_wait),
        .mem_address(mem_address), .mem_req(mem_req), .mem_write(mem_write),
        .mem_byte_en(mem_byte_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state: owner 0 = nobody, 1 = instruction, 2 = data
    int          m_owner;
    bit          m_i_pend, m_d_pend, m_d_write;
    logic [31:0] m_i_addr, m_d_addr, m_d_wdata;
    logic [2:0]  m_d_mode;
    int          m_starve;
    logic [31:0] m_imem_data, m_dmem_rdata;
    logic [31:0] m_exp_addr, m_exp_wdata;
    logic [3:0]  m_exp_be;
    bit          m_exp_write;

    // memory responder controls
    bit auto_resp, stray_ack, rand_lat;
    int ack_lat, m_gcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Applies one clock edge worth of the arbiter rules to the model.
    task automatic model_step();
        bit cap_i, cap_d, old_i, was_idle;
        int off;
        if (!reset_n) begin
            m_owner = 0; m_i_pend = 0; m_d_pend = 0; m_starve = 0;
            m_imem_data = 0; m_dmem_rdata = 0;
            return;
        end
        old_i    = m_i_pend;
        was_idle = (m_owner == 0);
        cap_i    = imem_enable && !m_i_pend;
        cap_d    = dmem_enable && (dmem_read_enable || dmem_write_enable) && !m_d_pend;

        if (m_owner == 1 && mem_ack) begin
            m_imem_data = mem_read_data; m_i_pend = 0; m_owner = 0;
        end else if (m_owner == 2 && mem_ack) begin
            if (!m_d_write) begin
`ifdef MEM_ARBITER_BYTE_LANE_EN
                m_dmem_rdata = mem_read_data >> (8 * (m_d_addr % 4));
`else
                m_dmem_rdata = mem_read_data;
`endif
            end
            m_d_pend = 0; m_owner = 0;
        end

        if (cap_i) begin m_i_pend = 1; m_i_addr = imem_address; end
        if (cap_d) begin
            m_d_pend = 1; m_d_addr = dmem_address; m_d_wdata = dmem_write_data;
            m_d_mode = dmem_write_mode; m_d_write = dmem_write_enable;
        end

        if (was_idle) begin
            if (m_d_pend && (!m_i_pend || m_starve < STARVE)) begin
                m_owner = 2;
                if (old_i && m_starve < STARVE) m_starve++;
                m_exp_addr  = m_d_addr & 32'hFFFF_FFFC;
                m_exp_write = m_d_write;
`ifdef MEM_ARBITER_BYTE_LANE_EN
                off = int'(m_d_addr % 4);
                if (!m_d_write)          m_exp_be = 4'hF;
                else if (m_d_mode == 0)  m_exp_be = 4'((1 << off) & 15);
                else if (m_d_mode == 1)  m_exp_be = 4'((3 << off) & 15);
                else                     m_exp_be = 4'hF;
                m_exp_wdata = m_d_wdata << (8 * off);
`else
                off = 0;
                m_exp_be    = 4'hF;
                m_exp_wdata = m_d_wdata + 32'(off);
`endif
            end else if (m_i_pend) begin
                m_owner = 1; m_starve = 0;
                m_exp_addr = m_i_addr & 32'hFFFF_FFFC;
                m_exp_write = 0; m_exp_be = 4'hF;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_wait", 32'(imem_wait), 32'(m_i_pend));
        chk("dmem_wait", 32'(dmem_wait), 32'(m_d_pend));
        chk("mem_req", 32'(mem_req), 32'(m_owner != 0));
        chk("imem_data", imem_data, m_imem_data);
        chk("dmem_read_data", dmem_read_data, m_dmem_rdata);
        if (m_owner != 0) begin
            chk("mem_address", mem_address, m_exp_addr);
            chk("mem_write", 32'(mem_write), 32'(m_exp_write));
            chk("mem_byte_en", 32'(mem_byte_en), 32'(m_exp_be));
            if (m_exp_write) chk("mem_write_data", mem_write_data, m_exp_wdata);
        end
    endtask

    // One clock: model and DUT see the same edge, DUT sampled 1 time unit later,
    // then the memory responder picks the next-cycle ack.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (auto_resp) begin
            if (m_owner != 0) begin
                m_gcnt++;
                mem_ack = (m_gcnt > ack_lat);
            end else begin
                m_gcnt = 0;
                if (rand_lat) ack_lat = $urandom_range(0, 3);
                mem_ack = stray_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            mem_read_data = $urandom();
        end
    endtask

    initial begin
        int          wcnt, ngrant;
        bit          seen_i, prev_req;
        logic [31:0] ack_data, prev_rd;

        reset_n = 0; imem_address = 0; imem_enable = 0;
        dmem_address = 0; dmem_enable = 0; dmem_write_data = 0;
        dmem_write_enable = 0; dmem_write_mode = 0; dmem_read_enable = 0;
        dmem_read_mode = 0; mem_read_data = 0; mem_ack = 0;
        auto_resp = 1; stray_ack = 0; rand_lat = 0; ack_lat = 1; m_gcnt = 0;
        m_owner = 0; m_i_pend = 0; m_d_pend = 0; m_d_write = 0; m_starve = 0;
        m_i_addr = 0; m_d_addr = 0; m_d_wdata = 0; m_d_mode = 0;
        m_imem_data = 0; m_dmem_rdata = 0; m_exp_addr = 0; m_exp_wdata = 0;
        m_exp_be = 0; m_exp_write = 0;
        ack_data = 0;

        // reset state
        repeat (3) cycle();
        chk("rst_mem_byte_en", 32'(mem_byte_en), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        reset_n = 1;
        cycle();

        // single fetch, ack one cycle after request
        imem_address = 32'h100; imem_enable = 1;
        cycle();
        imem_enable = 0;
        chk("s1_req", 32'(mem_req), 32'h1);
        chk("s1_addr", mem_address, 32'h100);
        wcnt = imem_wait ? 1 : 0;
        for (int k = 0; k < 5; k++) begin
            if (mem_ack && mem_req) ack_data = mem_read_data;
            cycle();
            if (imem_wait) wcnt++;
        end
        chk("s1_wait_cycles", wcnt, 2);
        chk("s1_imem_data", imem_data, ack_data);

        // minimum latency: ack in the same cycle as the request
        ack_lat = 0;
        imem_address = 32'h13; imem_enable = 1;
        cycle();
        imem_enable = 0;
        chk("lat_req", 32'(mem_req), 32'h1);
        chk("lat_addr", mem_address, 32'h10);
        cycle();
        chk("lat_wait_clear", 32'(imem_wait), 32'h0);

        // simultaneous capture: data first, then instruction
        ack_lat = 2;
        imem_address = 32'h40; imem_enable = 1;
        dmem_address = 32'h80; dmem_read_enable = 1; dmem_read_mode = 3'd2; dmem_enable = 1;
        cycle();
        imem_enable = 0; dmem_enable = 0;
        chk("s2_first_addr", mem_address, 32'h80);
        for (int k = 0; k < 20 && dmem_wait; k++) cycle();
        chk("s2_d_done", 32'(dmem_wait), 32'h0);
        chk("s2_i_still_wait", 32'(imem_wait), 32'h1);
        seen_i = 0;
        for (int k = 0; k < 20 && imem_wait; k++) begin
            cycle();
            if (mem_req && mem_address == 32'h40) seen_i = 1;
        end
        chk("s2_i_granted", 32'(seen_i), 32'h1);
        chk("s2_i_done", 32'(imem_wait), 32'h0);

        // starvation: fetch waits behind a stream of data reads
        ack_lat = 1;
        dmem_address = 32'h500; dmem_read_enable = 1; dmem_write_enable = 0; dmem_enable = 1;
        cycle();
        imem_address = 32'h300; imem_enable = 1;
        cycle();
        imem_enable = 0;
        ngrant = 0; seen_i = 0; prev_req = 1;
        for (int k = 0; k < 60 && !seen_i; k++) begin
            cycle();
            if (mem_req && !prev_req) begin
                if (mem_address == 32'h300) seen_i = 1;
                else if (imem_wait) ngrant++;
            end
            prev_req = mem_req;
        end
        chk("s3_i_granted", 32'(seen_i), 32'h1);
        chk("s3_data_grants_before_i", ngrant, 4);
        dmem_enable = 0;
        for (int k = 0; k < 20 && (dmem_wait || imem_wait); k++) cycle();
        chk("s3_drained", 32'({imem_wait, dmem_wait}), 32'h0);

        // byte write 0xAB at 0x203, then a read of the same byte
        prev_rd = dmem_read_data;
        dmem_address = 32'h203; dmem_write_data = 32'hAB; dmem_write_mode = 3'd0;
        dmem_write_enable = 1; dmem_read_enable = 0; dmem_enable = 1;
        cycle();
        dmem_enable = 0;
        chk("s4_addr", mem_address, 32'h200);
        chk("s4_write", 32'(mem_write), 32'h1);
`ifdef MEM_ARBITER_BYTE_LANE_EN
        chk("s4_be", 32'(mem_byte_en), 32'h8);
        chk("s4_wdata_lane", 32'(mem_write_data[31:24]), 32'hAB);
`else
        chk("s4_be", 32'(mem_byte_en), 32'hF);
        chk("s4_wdata", mem_write_data, 32'hAB);
`endif
        for (int k = 0; k < 20 && dmem_wait; k++) cycle();
        chk("s4_rdata_kept", dmem_read_data, prev_rd);
        dmem_write_enable = 0; dmem_read_enable = 1; dmem_enable = 1;
        cycle();
        dmem_enable = 0;
        for (int k = 0; k < 20 && dmem_wait; k++) begin
            if (mem_ack && mem_req) ack_data = mem_read_data;
            cycle();
        end
`ifdef MEM_ARBITER_BYTE_LANE_EN
        chk("s4_read_shift", dmem_read_data, ack_data >> 24);
`else
        chk("s4_read_plain", dmem_read_data, ack_data);
`endif

        // reset during a data grant; ack arrives after reset
        auto_resp = 0; mem_ack = 0;
        dmem_address = 32'h44; dmem_read_enable = 1; dmem_enable = 1;
        cycle();
        dmem_enable = 0;
        chk("s5_granted", 32'(mem_req), 32'h1);
        reset_n = 0;
        cycle();
        reset_n = 1; mem_ack = 1; mem_read_data = 32'hDEAD_BEEF;
        cycle();
        mem_ack = 0;
        chk("s5_req", 32'(mem_req), 32'h0);
        chk("s5_dwait", 32'(dmem_wait), 32'h0);
        chk("s5_rdata", dmem_read_data, 32'h0);
        cycle();
        chk("s5_rdata_after", dmem_read_data, 32'h0);
        auto_resp = 1;

        // dmem_enable without read or write is not a request
        dmem_enable = 1; dmem_read_enable = 0; dmem_write_enable = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("s6_no_req", 32'(mem_req), 32'h0);
            chk("s6_no_wait", 32'(dmem_wait), 32'h0);
        end
        dmem_enable = 0;

        // randomized traffic with stray acks, random latency and rare resets
        stray_ack = 1; rand_lat = 1;
        for (int k = 0; k < 600; k++) begin
            reset_n           = ($urandom_range(0, 99) != 0);
            imem_enable       = ($urandom_range(0, 3) == 0);
            imem_address      = $urandom();
            dmem_enable       = 1'($urandom_range(0, 1));
            dmem_read_enable  = 1'($urandom_range(0, 1));
            dmem_write_enable = 1'($urandom_range(0, 1));
            dmem_write_mode   = 3'($urandom_range(0, 3));
            dmem_read_mode    = 3'($urandom_range(0, 3));
            dmem_address      = $urandom();
            dmem_write_data   = $urandom();
            cycle();
        end
        reset_n = 1; imem_enable = 0; dmem_enable = 0; stray_ack = 0;
        for (int k = 0; k < 20 && (dmem_wait || imem_wait); k++) cycle();
        chk("final_idle", 32'({imem_wait, dmem_wait}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while an instruction request is pending.
REQ-002 SHALL have ports: clk  in  1  clock; reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have instruction-side ports: imem_address in 32; imem_enable in 1; imem_data out 32; imem_wait out 1.
REQ-004 SHALL have data-side inputs: dmem_address 32; dmem_enable 1; dmem_write_data 32; dmem_write_enable 1; dmem_write_mode 3; dmem_read_enable 1; dmem_read_mode 3.
REQ-005 SHALL have data-side outputs: dmem_read_data 32; dmem_wait 1.
REQ-006 SHALL have memory-side ports: mem_address out 32 (word-aligned); mem_req out 1; mem_write out 1; mem_byte_en out 4; mem_write_data out 32; mem_read_data in 32; mem_ack in 1 (read data valid in the ack cycle).

Function
REQ-007 SHALL capture an instruction request at a clk edge where imem_enable=1 and no instruction request is pending: latch the address and set i_pending.
REQ-008 SHALL capture a data request at an edge where dmem_enable=1, (dmem_read_enable|dmem_write_enable)=1 and no data request is pending: latch address, data, modes, direction; set d_pending.
REQ-009 SHALL ignore enable while that requester's own request is pending; dmem_enable without read or write SHALL be a no-op.
REQ-010 SHALL drive imem_wait=i_pending and dmem_wait=d_pending, both registered.
REQ-011 SHALL use an FSM IDLE/GRANT_I/GRANT_D: IDLE->GRANT_x when any request is pending; GRANT_x->IDLE at the edge where mem_ack=1.
REQ-012 SHALL grant data over instruction when both are pending, unless the starve counter equals STARVE_LIMIT, in which case instruction wins.
REQ-013 SHALL increment the starve counter on each data grant made while i_pending=1, clear it on each instruction grant, and saturate it at STARVE_LIMIT.
REQ-014 SHALL hold mem_req=1 and all mem_* outputs stable through GRANT_x until ack; mem_req=0 in IDLE.
REQ-015 SHALL drive mem_address from captured address bits [31:2] with bits [1:0]=0.
REQ-016 SHALL, on an ack in GRANT_I, register mem_read_data into imem_data and clear i_pending at the same edge.
REQ-017 SHALL, on an ack in GRANT_D for a read, register mem_read_data shifted right by 8*address[1:0] into dmem_read_data; writes leave dmem_read_data unchanged; d_pending clears at that edge.
REQ-018 SHALL hold imem_data/dmem_read_data stable until the next completion of the same requester.
REQ-019 SHALL keep minimum latency at capture edge N, mem_req in cycle N+1, and wait deasserted in cycle N+2 given an ack in N+1.
REQ-020 SHALL ignore mem_ack in IDLE.

Reset
REQ-021 SHALL, with reset_n=0 at an edge: state=IDLE; i_pending=d_pending=0; starve counter=0; imem_data=dmem_read_data=0; mem_req=mem_write=0; mem_byte_en=0.
REQ-022 SHALL, on reset mid-transaction, drop the request and discard any ack arriving after reset.

Configuration
REQ-023 SHALL use macro MEM_ARBITER_BYTE_LANE_EN.
REQ-024 SHALL, when defined, drive write byte enables as follows: mode 000 -> 4'b0001<<addr[1:0]; mode 001 -> 4'b0011<<addr[1:0]; mode 010 -> 4'b1111. Write data SHALL be shifted left by 8*addr[1:0]; reads use 4'b1111.
REQ-025 SHALL, when undefined, force mem_byte_en=4'b1111, pass write data unshifted, and deliver read data unshifted.

Verification
REQ-026 SHALL cover: imem_enable=1, addr 0x100, ack 1 cycle after req -> mem_address=0x100, imem_data=mem_read_data, imem_wait high exactly 2 cycles.
REQ-027 SHALL cover: imem and dmem read captured same edge -> dmem granted first, then imem; each wait clears on its own ack.
REQ-028 SHALL cover: imem pending, 6 back-to-back dmem reads, STARVE_LIMIT=4 -> imem granted after 4th data grant.
REQ-029 SHALL cover (MEM_ARBITER_BYTE_LANE_EN): byte write 0xAB at 0x203 -> mem_byte_en=4'b1000, mem_write_data[31:24]=0xAB, mem_address=0x200.
REQ-030 SHALL cover: reset_n=0 during GRANT_D, ack on next cycle -> mem_req=0, dmem_wait=0, dmem_read_data=0.
REQ-031 SHALL cover: dmem_enable=1, read/write enables 0 -> no capture, mem_req stays 0.
